// File: rtl/mem_sequencer_pkg.sv
// rtl/mem_sequencer_pkg.sv - shared op codes, state encoding and widths for mem_sequencer
//
// Purpose : single home for the command op codes and the sequencer state
//           encoding so the RTL and any bench agree on the values.
// Ports   : none (package).
package mem_sequencer_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned OP_W   = 2;

   typedef enum logic [OP_W-1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_COPY  = 2'b10,
      OP_FILL  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_A  = 3'd1,
      ST_RD_D  = 3'd2,
      ST_WR    = 3'd3,
      ST_CP_RA = 3'd4,
      ST_CP_WR = 3'd5,
      ST_DONE  = 3'd6
   } state_e;

endpackage

// File: rtl/mem_sequencer_if.sv
// rtl/mem_sequencer_if.sv - command and RAM bus bundle for mem_sequencer
//
// Purpose : groups the command handshake, status and RAM port signals.
// Signals : req/op/addr/src_addr/len/wdata  command from requester
//           busy/done/rdata                 status back to requester
//           mem_addr/mem_data/mem_we        RAM write/address port
//           mem_q                           RAM read data (one cycle after mem_addr)
// Modports: slave  - the sequencer
//           master - requester plus RAM side
interface mem_sequencer_if;
   import mem_sequencer_pkg::*;

   logic                  req;
   logic [OP_W-1:0]       op;
   logic [ADDR_W-1:0]     addr;
   logic [ADDR_W-1:0]     src_addr;
   logic [ADDR_W-1:0]     len;
   logic [DATA_W-1:0]     wdata;
   logic                  busy;
   logic                  done;
   logic [DATA_W-1:0]     rdata;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_data;
   logic                  mem_we;
   logic [DATA_W-1:0]     mem_q;

   modport slave (
      input  req, op, addr, src_addr, len, wdata, mem_q,
      output busy, done, rdata, mem_addr, mem_data, mem_we
   );

   modport master (
      output req, op, addr, src_addr, len, wdata, mem_q,
      input  busy, done, rdata, mem_addr, mem_data, mem_we
   );

endinterface

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - LOAD/STORE/COPY/FILL command sequencer for a 16x16 RAM
//
// Purpose : accepts one command at a time and walks the RAM port through it.
//           LOAD  : RD_A -> RD_D -> DONE
//           STORE : WR -> DONE
//           FILL  : WR x (len+1) -> DONE
//           COPY  : (CP_RA -> CP_WR) x (len+1) -> DONE, ascending addresses
// Ports   : clk      sole clock, rising edge
//           rst      synchronous active-high reset
//           bus      mem_sequencer_if.slave (command, status, RAM port)
module mem_sequencer
   import mem_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   mem_sequencer_if.slave    bus
);

   state_e              r_state;
   state_e              w_state_nxt;

   logic [ADDR_W-1:0]   r_dst;
   logic [ADDR_W-1:0]   r_src;
   logic [ADDR_W-1:0]   r_cnt;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;

   logic [ADDR_W-1:0]   w_dst_nxt;
   logic [ADDR_W-1:0]   w_src_nxt;
   logic [ADDR_W-1:0]   w_cnt_nxt;
   logic [DATA_W-1:0]   w_wdata_nxt;
   logic [DATA_W-1:0]   w_rdata_nxt;

   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_data;
   logic                w_mem_we;
   logic                w_done;
   logic                w_ready;
   logic                w_accept;

   // DONE counts as ready so a new command can follow with no idle gap.
   assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_accept = bus.req && w_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_dst   <= '0;
         r_src   <= '0;
         r_cnt   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dst   <= w_dst_nxt;
         r_src   <= w_src_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wdata <= w_wdata_nxt;
         r_rdata <= w_rdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dst_nxt   = r_dst;
      w_src_nxt   = r_src;
      w_cnt_nxt   = r_cnt;
      w_wdata_nxt = r_wdata;
      w_rdata_nxt = r_rdata;
      w_mem_addr  = '0;
      w_mem_data  = '0;
      w_mem_we    = 1'b0;
      w_done      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_IDLE;
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         ST_RD_A: begin
            w_mem_addr  = r_dst;
            w_state_nxt = ST_RD_D;
         end
         ST_RD_D: begin
            // RAM registered the address at the end of RD_A, so mem_q is valid now.
            w_rdata_nxt = bus.mem_q;
            w_state_nxt = ST_DONE;
         end
         ST_WR: begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_dst;
            w_mem_data = r_wdata;
            if (r_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
               w_dst_nxt = r_dst + 1'b1;
            end
         end
         ST_CP_RA: begin
            w_mem_addr  = r_src;
            w_state_nxt = ST_CP_WR;
         end
         ST_CP_WR: begin
            // Source word read in CP_RA; a word written by an earlier CP_WR is
            // visible here, which gives sequential-copy semantics on overlap.
            w_mem_we   = 1'b1;
            w_mem_addr = r_dst;
            w_mem_data = bus.mem_q;
            if (r_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_cnt_nxt   = r_cnt - 1'b1;
               w_dst_nxt   = r_dst + 1'b1;
               w_src_nxt   = r_src + 1'b1;
               w_state_nxt = ST_CP_RA;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_accept) begin
         w_dst_nxt   = bus.addr;
         w_src_nxt   = bus.src_addr;
         w_wdata_nxt = bus.wdata;
         case (op_e'(bus.op))
            OP_LOAD: begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_RD_A;
            end
            OP_STORE: begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_WR;
            end
            OP_COPY: begin
               w_cnt_nxt   = bus.len;
               w_state_nxt = ST_CP_RA;
            end
            OP_FILL: begin
               w_cnt_nxt   = bus.len;
               w_state_nxt = ST_WR;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = ~w_ready;
   assign bus.done     = w_done;
   assign bus.rdata    = r_rdata;
   assign bus.mem_addr = w_mem_addr;
   assign bus.mem_data = w_mem_data;
   assign bus.mem_we   = w_mem_we;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - self-checking bench for mem_sequencer with 16x16 RAM model
module tb_mem_sequencer;
   import mem_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_sequencer_if bus ();

   mem_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 16x16 RAM: synchronous write, registered read address.
   logic [15:0] ram [16];
   logic [3:0]  r_raddr;

   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_data;
      r_raddr <= bus.mem_addr;
   end

   assign bus.mem_q = ram[r_raddr];

   // Reference model state
   logic [15:0] ref_mem [16];
   logic [15:0] ref_rdata;
   int          n_cmp;
   int          n_fail;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("%s_word%0d", tag, i), {16'h0, ram[i]}, {16'h0, ref_mem[i]});
      end
   endtask

   task automatic scramble();
      bus.req      = 1'b0;
      bus.op       = 2'($urandom);
      bus.addr     = 4'($urandom);
      bus.src_addr = 4'($urandom);
      bus.len      = 4'($urandom);
      bus.wdata    = 16'($urandom);
   endtask

   // Issue one command from a negedge (DUT in IDLE or DONE); returns at the
   // negedge of the DONE cycle. poke=1 raises a STORE to word 5 in c2 only.
   task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] s,
                         input logic [3:0] l, input logic [15:0] wd, input bit poke);
      int n;
      int lat;
      int k;
      bit seen;
      n = int'(l) + 1;
      case (op)
         2'b00:   lat = 3;
         2'b01:   lat = 2;
         2'b10:   lat = 2 * n + 1;
         default: lat = n + 1;
      endcase
      case (op)
         2'b00: ref_rdata = ref_mem[a];
         2'b01: ref_mem[a] = wd;
         2'b10: for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 16] = ref_mem[(int'(s) + i) % 16];
         default: for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 16] = wd;
      endcase

      bus.req      = 1'b1;
      bus.op       = op;
      bus.addr     = a;
      bus.src_addr = s;
      bus.len      = l;
      bus.wdata    = wd;
      @(posedge clk);
      @(negedge clk);
      scramble();
      k    = 1;
      seen = 1'b0;
      while (k <= lat + 4 && !seen) begin
         if (k > 1) @(negedge clk);
         if (poke && k == 2) begin
            bus.req   = 1'b1;
            bus.op    = 2'b01;
            bus.addr  = 4'd5;
            bus.wdata = 16'h5555;
         end else if (poke && k == 3) begin
            bus.req = 1'b0;
         end
         if (bus.done === 1'b1) begin
            seen = 1'b1;
         end else begin
            chk($sformatf("busy_c%0d", k), {31'h0, bus.busy}, 32'd1);
            k++;
         end
      end
      chk("done_latency", seen ? k : -1, lat);
      if (seen) begin
         chk("done_busy",     {31'h0, bus.busy},     32'd0);
         chk("done_mem_we",   {31'h0, bus.mem_we},   32'd0);
         chk("done_mem_addr", {28'h0, bus.mem_addr}, 32'd0);
         chk("done_mem_data", {16'h0, bus.mem_data}, 32'd0);
         chk("done_rdata",    {16'h0, bus.rdata},    {16'h0, ref_rdata});
      end
   endtask

   initial begin
      logic [1:0]  rop;
      logic [3:0]  ra;
      logic [3:0]  rs;
      logic [3:0]  rl;
      logic [15:0] rw;
      int          k;
      bit          any_done;

      n_cmp     = 0;
      n_fail    = 0;
      ref_rdata = 16'h0;
      scramble();

      // Reset with req held high: reset must win.
      rst     = 1'b1;
      bus.req = 1'b1;
      bus.op  = 2'b01;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",     {31'h0, bus.busy},     32'd0);
      chk("rst_done",     {31'h0, bus.done},     32'd0);
      chk("rst_rdata",    {16'h0, bus.rdata},    32'd0);
      chk("rst_mem_we",   {31'h0, bus.mem_we},   32'd0);
      chk("rst_mem_addr", {28'h0, bus.mem_addr}, 32'd0);
      chk("rst_mem_data", {16'h0, bus.mem_data}, 32'd0);
      rst = 1'b0;
      scramble();
      @(negedge clk);

      // Initialise all of RAM through a full-range FILL.
      do_cmd(2'b11, 4'd0, 4'd0, 4'd15, 16'($urandom), 1'b0);
      @(negedge clk);
      check_mem("init");

      // STORE then LOAD of 0xBEEF at word 3.
      do_cmd(2'b01, 4'd3, 4'd0, 4'd0, 16'hBEEF, 1'b0);
      @(negedge clk);
      do_cmd(2'b00, 4'd3, 4'd0, 4'd0, 16'h0, 1'b0);
      chk("load_beef", {16'h0, bus.rdata}, 32'h0000BEEF);
      @(negedge clk);

      // FILL wrapping 14,15,0,1; word 2 must stay untouched.
      do_cmd(2'b01, 4'd2, 4'd0, 4'd0, 16'h1234, 1'b0);
      @(negedge clk);
      do_cmd(2'b11, 4'd14, 4'd0, 4'd3, 16'h00AA, 1'b0);
      chk("fill_w2_kept", {16'h0, ram[2]}, 32'h00001234);
      chk("fill_w0",      {16'h0, ram[0]}, 32'h000000AA);
      check_mem("fill_wrap");
      @(negedge clk);

      // Overlapping COPY src=0 dst=1 len=2 after preload 1,2,3,4.
      for (int i = 0; i < 4; i++) begin
         do_cmd(2'b01, 4'(i), 4'd0, 4'd0, 16'(i + 1), 1'b0);
      end
      @(negedge clk);
      do_cmd(2'b10, 4'd1, 4'd0, 4'd2, 16'h0, 1'b0);
      chk("copy_w1", {16'h0, ram[1]}, 32'd1);
      chk("copy_w2", {16'h0, ram[2]}, 32'd1);
      chk("copy_w3", {16'h0, ram[3]}, 32'd1);
      check_mem("copy_ovl");
      @(negedge clk);

      // STORE to word 5 raised during a FILL of 8..15 must be ignored.
      do_cmd(2'b11, 4'd8, 4'd0, 4'd7, 16'hC0DE, 1'b1);
      check_mem("ignored_req");
      @(negedge clk);

      // Reset in c3 of a COPY len=7 (src 8, dst 0): only word 0 copied.
      ref_mem[0]   = ref_mem[8];
      bus.req      = 1'b1;
      bus.op       = 2'b10;
      bus.addr     = 4'd0;
      bus.src_addr = 4'd8;
      bus.len      = 4'd7;
      @(posedge clk);
      @(negedge clk);
      scramble();
      any_done = 1'b0;
      @(negedge clk);
      any_done = any_done | bus.done;
      @(negedge clk);
      any_done = any_done | bus.done;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ref_rdata = 16'h0;
      chk("abort_busy",   {31'h0, bus.busy},     32'd0);
      chk("abort_mem_we", {31'h0, bus.mem_we},   32'd0);
      chk("abort_addr",   {28'h0, bus.mem_addr}, 32'd0);
      chk("abort_rdata",  {16'h0, bus.rdata},    32'd0);
      for (int i = 0; i < 16; i++) begin
         any_done = any_done | bus.done;
         @(negedge clk);
      end
      chk("abort_no_done", {31'h0, any_done}, 32'd0);
      check_mem("abort");

      // STORE then LOAD accepted in the STORE's DONE cycle.
      do_cmd(2'b01, 4'd9, 4'd0, 4'd0, 16'h7A5C, 1'b0);
      do_cmd(2'b00, 4'd9, 4'd0, 4'd0, 16'h0, 1'b0);
      chk("b2b_rdata", {16'h0, bus.rdata}, 32'h00007A5C);
      @(negedge clk);

      // Random commands, with random zero/one idle cycle between them.
      for (int t = 0; t < 40; t++) begin
         rop = 2'($urandom);
         ra  = 4'($urandom);
         rs  = 4'($urandom);
         rl  = 4'($urandom);
         rw  = 16'($urandom);
         do_cmd(rop, ra, rs, rl, rw, 1'b0);
         check_mem($sformatf("rand%0d", t));
         k = int'($urandom_range(0, 1));
         if (k == 1) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
